// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, FSM states and lane helpers for the data memory LSU
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    function automatic logic f3_legal(input logic [2:0] funct3);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_H, F3_HU: return offset[0];
            F3_W:        return offset != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_B, F3_BU: return 4'b0001 << offset;
            F3_H, F3_HU: return 4'b0011 << offset;
            default:     return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - selects the addressed lane of a loaded word and sign/zero extends it
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted  = word_i >> {offset_i, 3'b000};
        result_o = '0;
        case (funct3_i)
            F3_B:    result_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    result_o = word_i;
            F3_BU:   result_o = {24'h0, shifted[7:0]};
            F3_HU:   result_o = {16'h0, shifted[15:0]};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/pipeline_dmem_lsu.sv
// rtl/pipeline_dmem_lsu.sv - byte-addressed data memory with load/store unit and post-reset clear sweep
module pipeline_dmem_lsu
    import dmem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DEPTH_WORDS    = 64,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic              rsp_valid,
    output logic [31:0]       read_data,
    output logic              misalign,
    output logic              illegal
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic [31:0]      mem_q [DEPTH_WORDS];

    logic             rsp_valid_q, misalign_q, illegal_q;
    logic [31:0]      rd_word_q;
    logic [2:0]       rd_f3_q;
    logic [1:0]       rd_off_q;

    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             accept, legal, mis, access_ok;
    logic [3:0]       mask;
    logic [31:0]      wdata_rep;
    logic             unused_addr;

    assign idx         = address[IDX_W+1:2];
    assign off         = address[1:0];
    assign unused_addr = ^address[ADDR_W-1:IDX_W+2];

    // Gating with reset keeps the requester from seeing a ready that reset is about to revoke.
    assign req_ready = (state_q == ST_READY) && !reset;
    assign accept    = req_valid && req_ready;
    assign legal     = f3_legal(req_funct3);
    assign mis       = f3_misaligned(req_funct3, off);
    assign access_ok = legal && !mis;
    assign mask      = lane_mask(req_funct3, off);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
                state_d = ST_READY;
            end
        end
    end

    always_comb begin
        wdata_rep = write_data;
        case (req_funct3)
            F3_B, F3_BU: wdata_rep = {4{write_data[7:0]}};
            F3_H, F3_HU: wdata_rep = {2{write_data[15:0]}};
            default:     wdata_rep = write_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_idx_q] <= '0;
            end else if (accept && req_write && access_ok) begin
                for (int b = 0; b < 4; b++) begin
                    if (mask[b]) begin
                        mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                    end
                end
            end
        end
    end

    // Rejected loads capture a zero word so the aligner yields 0 regardless of funct3.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
            illegal_q   <= 1'b0;
            rd_word_q   <= '0;
            rd_f3_q     <= '0;
            rd_off_q    <= '0;
        end else begin
            rsp_valid_q <= accept && !req_write;
            misalign_q  <= accept && legal && mis;
            illegal_q   <= accept && !legal;
            if (accept && !req_write) begin
                rd_word_q <= access_ok ? mem_q[idx] : '0;
                rd_f3_q   <= req_funct3;
                rd_off_q  <= off;
            end
        end
    end

    dmem_load_align u_align (
        .word_i   (rd_word_q),
        .offset_i (rd_off_q),
        .funct3_i (rd_f3_q),
        .result_o (read_data)
    );

    assign rsp_valid = rsp_valid_q;
    assign misalign  = misalign_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_pipeline_dmem_lsu.sv
// tb/tb_pipeline_dmem_lsu.sv - directed self-checking bench for pipeline_dmem_lsu
module tb_pipeline_dmem_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b010;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        rsp_valid;
    logic [31:0] read_data;
    logic        misalign;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_dmem_lsu #(.ADDR_W(32), .DEPTH_WORDS(64), .CLEAR_ON_RESET(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .address    (address),
        .write_data (write_data),
        .rsp_valid  (rsp_valid),
        .read_data  (read_data),
        .misalign   (misalign),
        .illegal    (illegal)
    );

    // Called at a negedge: presents one request across the next posedge, returns at the following negedge.
    task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        address    = a;
        write_data = d;
        @(negedge clk);
        req_valid  = 1'b0;
        req_write  = 1'b0;
    endtask

    task automatic test_reset;
        int cnt;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, misalign, illegal} !== 4'b0000 || read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b mis=%b ill=%b data=%h required all zero",
                     req_ready, rsp_valid, misalign, illegal, read_data);
        end
        reset = 1'b0;
        cnt = 0;
        while (!req_ready && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 64) begin
            errors++;
            $display("FAIL clear_duration: got %0d cycles required 64", cnt);
        end
        drive(1'b0, 3'b010, 32'h3C, 32'h0);
        checks++;
        if (rsp_valid !== 1'b1 || read_data !== 32'h0) begin
            errors++;
            $display("FAIL lw_after_clear: got vld=%b data=%h required vld=1 data=00000000", rsp_valid, read_data);
        end
    endtask

    task automatic test_load_ext;
        logic [2:0]  f3s  [6] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] addrs[6] = '{32'h10, 32'h11, 32'h12, 32'h12, 32'h12, 32'h12};
        logic [31:0] exps [6] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF,
                                  32'h000000FF, 32'hFFFF80FF, 32'h000080FF};
        drive(1'b1, 3'b010, 32'h10, 32'h80FF7F01);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_no_rsp: got vld=%b required 0", rsp_valid);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, f3s[i], addrs[i], 32'h0);
            checks++;
            if (rsp_valid !== 1'b1 || read_data !== exps[i] || misalign !== 1'b0) begin
                errors++;
                $display("FAIL load_ext_%0d: got vld=%b data=%h mis=%b required vld=1 data=%h mis=0",
                         i, rsp_valid, read_data, misalign, exps[i]);
            end
        end
    endtask

    task automatic test_byte_store;
        drive(1'b1, 3'b010, 32'h20, 32'h11223344);
        drive(1'b1, 3'b000, 32'h21, 32'hDEADBEAB);
        drive(1'b0, 3'b010, 32'h20, 32'h0);
        checks++;
        if (read_data !== 32'h1122AB44) begin
            errors++;
            $display("FAIL sb_merge: got %h required 1122ab44", read_data);
        end
        drive(1'b1, 3'b001, 32'h22, 32'hCAFE5566);
        drive(1'b0, 3'b010, 32'h20, 32'h0);
        checks++;
        if (read_data !== 32'h5566AB44) begin
            errors++;
            $display("FAIL sh_merge: got %h required 5566ab44", read_data);
        end
    endtask

    task automatic test_misalign;
        drive(1'b1, 3'b010, 32'h04, 32'h12345678);
        drive(1'b1, 3'b010, 32'h06, 32'hFFFFFFFF);
        checks++;
        if (misalign !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL sw_misalign_flag: got mis=%b vld=%b required mis=1 vld=0", misalign, rsp_valid);
        end
        drive(1'b0, 3'b010, 32'h04, 32'h0);
        checks++;
        if (read_data !== 32'h12345678 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL sw_misalign_nowrite: got data=%h mis=%b required 12345678 mis=0", read_data, misalign);
        end
        drive(1'b0, 3'b001, 32'h03, 32'h0);
        checks++;
        if (rsp_valid !== 1'b1 || read_data !== 32'h0 || misalign !== 1'b1) begin
            errors++;
            $display("FAIL lh_misalign: got vld=%b data=%h mis=%b required vld=1 data=0 mis=1",
                     rsp_valid, read_data, misalign);
        end
        @(negedge clk);
        checks++;
        if (misalign !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse: got mis=%b vld=%b required 0 0", misalign, rsp_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] vals[4] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        for (int i = 0; i < 4; i++) drive(1'b1, 3'b010, 32'(4 * i), vals[i]);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        for (int i = 0; i < 4; i++) begin
            address = 32'(4 * i);
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || read_data !== vals[i]) begin
                errors++;
                $display("FAIL b2b_rsp_%0d: got vld=%b data=%h required vld=1 data=%h",
                         i, rsp_valid, read_data, vals[i]);
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || read_data !== vals[3]) begin
            errors++;
            $display("FAIL b2b_end: got vld=%b data=%h required vld=0 data=%h", rsp_valid, read_data, vals[3]);
        end
    endtask

    task automatic test_illegal;
        drive(1'b1, 3'b011, 32'h00, 32'h55555555);
        checks++;
        if (illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_store_flag: got %b required 1", illegal);
        end
        drive(1'b0, 3'b011, 32'h00, 32'h0);
        checks++;
        if (illegal !== 1'b1 || rsp_valid !== 1'b1 || read_data !== 32'h0) begin
            errors++;
            $display("FAIL illegal_load: got ill=%b vld=%b data=%h required 1 1 00000000", illegal, rsp_valid, read_data);
        end
        drive(1'b0, 3'b010, 32'h00, 32'h0);
        checks++;
        if (illegal !== 1'b0 || read_data !== 32'hA0A0A0A0) begin
            errors++;
            $display("FAIL illegal_nowrite: got ill=%b data=%h required ill=0 data=a0a0a0a0", illegal, read_data);
        end
    endtask

    task automatic test_reset_mid_clear;
        int cnt;
        int rsp_seen;
        rsp_seen = 0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        reset      = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        address    = 32'h20;
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b0;
        cnt = 0;
        while (!req_ready && cnt < 200) begin
            if (rsp_valid) rsp_seen++;
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 64) begin
            errors++;
            $display("FAIL restart_clear_duration: got %0d cycles required 64", cnt);
        end
        checks++;
        if (rsp_seen != 0) begin
            errors++;
            $display("FAIL restart_no_rsp: got %0d responses required 0", rsp_seen);
        end
        drive(1'b0, 3'b010, 32'h20, 32'h0);
        checks++;
        if (rsp_valid !== 1'b1 || read_data !== 32'h0) begin
            errors++;
            $display("FAIL restart_cleared: got vld=%b data=%h required vld=1 data=00000000", rsp_valid, read_data);
        end
    endtask

    initial begin
        test_reset;
        test_load_ext;
        test_byte_store;
        test_misalign;
        test_back_to_back;
        test_illegal;
        test_reset_mid_clear;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_dmem_lsu.md
Name: pipeline_dmem_lsu

Overview:
- Parametrised, byte-addressed RISC-V data memory with load/store unit for the pipelined core's MEM stage.
- Supports LB/LH/LW/LBU/LHU and SB/SH/SW, with byte-lane write masks and sign/zero extension.
- One-cycle registered read latency; flags misaligned accesses.
- After reset, a clear sequencer zeroes the array before the block accepts requests.

Parameters:
- ADDR_W, 32: width of the address input.
- DEPTH_WORDS, 64: number of 32-bit words; must be a power of 2, at least 2.
- CLEAR_ON_RESET, 1: 1 = sweep the array to zero after reset; 0 = go straight to READY.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  block accepts a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- address  in  ADDR_W  byte address.
- write_data  in  32  store data, LSB-aligned.
- rsp_valid  out  1  read_data valid (loads only).
- read_data  out  32  extended load result.
- misalign  out  1  one-cycle pulse, registered with the response slot.
- illegal  out  1  one-cycle pulse for an unsupported funct3.

Behaviour:
- Reset (synchronous, active-high):
  - rsp_valid=0, read_data=0, misalign=0, illegal=0, req_ready=0.
  - The FSM enters CLEAR if CLEAR_ON_RESET=1, else READY.
  - Reset asserted mid-CLEAR or mid-request restarts CLEAR from word 0. Any accepted-but-unresponded load is dropped (no rsp_valid).
- FSM:
  - CLEAR: a counter clr_idx runs 0..DEPTH_WORDS-1 and writes 0 to word clr_idx each cycle; req_ready=0. When clr_idx = DEPTH_WORDS-1, go to READY next cycle. Duration is DEPTH_WORDS cycles.
  - READY: req_ready=1. No other states.
- Accept: req_valid & req_ready.
- Word index = address[log2(DEPTH_WORDS)+1:2]; byte offset = address[1:0]. Upper address bits are ignored (wrap-around modulo array size).
- Alignment:
  - H/HU require offset[0]=0; W requires offset=00.
  - A misaligned or illegal request raises the corresponding flag next cycle and does not write the array.
  - A misaligned or illegal load still returns rsp_valid=1 with read_data=0.
- Store: the array is written at the accepting edge. Byte mask is 0001<<off for B, 0011<<off for H, 1111 for W. Data is replicated across lanes (B: 4x byte, H: 2x half). No response is generated.
- Load:
  - The word is read at the accepting edge into a registered stage, along with funct3 and offset.
  - The next cycle, rsp_valid=1 and read_data holds the lane selected by offset, sign-extended for B/H and zero-extended for BU/HU.
  - Latency is exactly 1 cycle; back-to-back loads give back-to-back responses.
- Load immediately after a store to the same word returns the new data, because the store was written at the previous edge.
- Between responses, rsp_valid=0 and read_data holds its last value.

Decomposition:
- Shared package dmem_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - FSM state encoding (ST_CLEAR, ST_READY).
  - Helper function for lane mask generation.
- Sub-module dmem_load_align: purely combinational. Takes the 32-bit word, offset and funct3, and produces the extended result. It is instantiated in the response stage.

Test Plan:
- Reset with DEPTH_WORDS=64 -> req_ready stays low for exactly 64 cycles, then goes high. A subsequent LW at address 0x3C returns 0x00000000 one cycle later.
- SW 0x80FF7F01 at 0x10, then LB/LBU/LH/LHU at 0x10, 0x11, 0x12 -> LB@0x10=0x00000001; LB@0x11=0x0000007F; LB@0x12=0xFFFFFFFF; LBU@0x12=0x000000FF; LH@0x12=0xFFFF80FF; LHU@0x12=0x000080FF.
- SB 0xAB at 0x21 over an existing word 0x11223344 -> LW@0x20 returns 0x1122AB44.
- SW to 0x06 (misaligned) -> misalign pulses one cycle later and memory is unchanged. LH at 0x03 -> rsp_valid=1, read_data=0, misalign=1.
- Assert reset during CLEAR at clr_idx=20 -> req_ready remains low for a further full 64 cycles, and no response appears.
- Issue 4 back-to-back LWs at 0x00, 0x04, 0x08, 0x0C -> rsp_valid is high for exactly 4 consecutive cycles, starting one cycle after the first request, with data in order. funct3=011 -> illegal=1 one cycle later.
